// File: rtl/msb_pe_decoder_if.sv
// Index stream in, decoded one-hot stream out: the handshake bundle around msb_pe_decoder.
`timescale 1ns/1ps
interface msb_pe_decoder_if #(
    parameter int IDX_W = 3
);
    localparam int OUT_W = 2 ** IDX_W;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, in_idx, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx
    );

    modport slave (
        input  in_valid, in_idx, out_ready,
        output in_ready, out_valid, out_onehot, out_idx
    );
endinterface

// File: rtl/msb_pe_decoder.sv
// Two-entry FIFO of encoded indices, decoded to one-hot at the head, with a sticky
// record of every grant line delivered since reset or the last mask clear.
`timescale 1ns/1ps
module msb_pe_decoder #(
    parameter int IDX_W = 3,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    msb_pe_decoder_if.slave       bus,
    input  logic                  mask_clr,
    output logic [2**IDX_W-1:0]   served_mask,
    output logic [1:0]            occupancy
);
    localparam int OUT_W = 2 ** IDX_W;

    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("msb_pe_decoder supports DEPTH == 2 only");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic [OUT_W-1:0] onehot;
    logic             head_valid;
    logic             push;
    logic             pop;

    // in_ready looks only at registered state, so there is no path from out_ready.
    assign bus.in_ready  = !rst && (state_q != FULL);
    assign head_valid    = (state_q != EMPTY);
    assign bus.out_valid = head_valid;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = head_valid && bus.out_ready;

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_decode
            assign onehot[gi] = head_valid && (head_q == IDX_W'(gi));
        end
    endgenerate

    assign bus.out_onehot = onehot;
    assign bus.out_idx    = head_valid ? head_q : '0;
    assign served_mask    = mask_q;
    assign occupancy      = state_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = bus.in_idx;
                end
            end
            ONE: begin
                // Push and pop together: the new index replaces the departing head.
                if (push && pop) begin
                    head_d = bus.in_idx;
                end else if (push) begin
                    state_d = FULL;
                    tail_d  = bus.in_idx;
                end else if (pop) begin
                    state_d = EMPTY;
                    head_d  = '0;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                    tail_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                head_d  = '0;
                tail_d  = '0;
            end
        endcase
    end

    // Clear is applied before the OR, so a line popped on the clear edge survives.
    always_comb begin
        mask_d = (mask_clr ? '0 : mask_q) | (pop ? onehot : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            mask_q  <= mask_d;
        end
    end
endmodule
